// File: rtl/mux_n_skid.sv
// N-way select into a 2-entry skid buffer; 1-cycle latency from accept to out_valid.
// in_ready comes only from registered state, so out_ready never reaches it combinationally.
module mux_n_skid #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 4,
  parameter int SEL_W  = 2
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_sel_oor,
  output logic                   out_valid,
  input  logic                   out_ready
);

  if ((2 ** SEL_W) < N_IN) begin : g_bad_sel_w
    $error("mux_n_skid: SEL_W too narrow for N_IN");
  end
  if ((N_IN < 2) || (N_IN > 16)) begin : g_bad_n_in
    $error("mux_n_skid: N_IN must be within 2..16");
  end

  // One extra bit so N_IN is representable even when 2**SEL_W == N_IN.
  localparam logic [SEL_W:0] N_IN_L = (SEL_W + 1)'(N_IN);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_dat_q, main_dat_d;
  logic                main_oor_q, main_oor_d;
  logic [DATA_W-1:0]   skid_dat_q, skid_dat_d;
  logic                skid_oor_q, skid_oor_d;

  logic [DATA_W-1:0]   sel_dat;
  logic                sel_oor;
  logic                accept;
  logic                drain;

  // Out-of-range selects fall through to the last input.
  always_comb begin
    sel_oor = ({1'b0, in_sel} >= N_IN_L);
    sel_dat = in_data[(N_IN-1)*DATA_W +: DATA_W];
    for (int k = 0; k < N_IN - 1; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_dat = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid   = (state_q != EMPTY);
  assign in_ready    = (state_q != FULL);
  assign out_data    = main_dat_q;
  assign out_sel_oor = main_oor_q;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_oor_d = main_oor_q;
    skid_dat_d = skid_dat_q;
    skid_oor_d = skid_oor_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d    = ONE;
            main_dat_d = sel_dat;
            main_oor_d = sel_oor;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_dat_d = sel_dat;
            main_oor_d = sel_oor;
          end else if (accept) begin
            state_d    = FULL;
            skid_dat_d = sel_dat;
            skid_oor_d = sel_oor;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d    = ONE;
            main_dat_d = skid_dat_q;
            main_oor_d = skid_oor_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= EMPTY;
      main_dat_q <= '0;
      main_oor_q <= 1'b0;
      skid_dat_q <= '0;
      skid_oor_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_dat_q <= main_dat_d;
      main_oor_q <= main_oor_d;
      skid_dat_q <= skid_dat_d;
      skid_oor_q <= skid_oor_d;
    end
  end

endmodule

// File: tb/tb_mux_n_skid.sv
// Directed and scoreboarded checks of mux_n_skid with N_IN=4 and N_IN=3 instances.
module tb_mux_n_skid;

  logic        clk;
  logic        arst_n;
  logic [63:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic        in_ready;
  logic [15:0] out_data;
  logic        out_sel_oor;
  logic        out_valid;

  logic        in_ready3;
  logic [15:0] out_data3;
  logic        out_sel_oor3;
  logic        out_valid3;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q[$];
  int          acc_n;
  int          cyc;
  logic        acc;
  logic        drn;

  mux_n_skid #(.DATA_W(16), .N_IN(4), .SEL_W(2)) u0 (
    .clk         (clk),
    .arst_n      (arst_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_data    (out_data),
    .out_sel_oor (out_sel_oor),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  mux_n_skid #(.DATA_W(16), .N_IN(3), .SEL_W(2)) u1 (
    .clk         (clk),
    .arst_n      (arst_n),
    .in_data     (in_data[47:0]),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready3),
    .flush       (flush),
    .out_data    (out_data3),
    .out_sel_oor (out_sel_oor3),
    .out_valid   (out_valid3),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst_n    = 1'b1;
    in_data   = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    check("rst_vld", out_valid, 0);
    check("rst_dat", out_data, 0);
    check("rst_oor", out_sel_oor, 0);
    check("rst_rdy", in_ready, 1);

    // Offer traffic while reset is held; nothing may be accepted.
    in_valid = 1'b1;
    in_sel   = 2'd2;
    tick();
    check("rst_noacc_vld", out_valid, 0);
    check("rst_noacc_dat", out_data, 0);
    arst_n   = 1'b1;
    in_valid = 1'b0;
    tick();
    check("post_rst_vld", out_valid, 0);
    check("post_rst_rdy", in_ready, 1);
    check("post_rst_dat", out_data, 0);
    check("post_rst_oor", out_sel_oor, 0);

    // Basic select, 1-cycle latency.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    tick();
    check("sel2_vld", out_valid, 1);
    check("sel2_dat", out_data, 16'h000C);
    check("sel2_oor", out_sel_oor, 0);

    // sel 3: in range for N_IN=4, out of range for N_IN=3.
    in_sel = 2'd3;
    tick();
    check("sel3_dat4", out_data, 16'h000D);
    check("sel3_oor4", out_sel_oor, 0);
    check("sel3_dat3", out_data3, 16'h000C);
    check("sel3_oor3", out_sel_oor3, 1);
    in_valid = 1'b0;
    tick();
    check("drain_empty", out_valid, 0);

    // Stall: fill both entries, hold, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    check("st1_dat", out_data, 16'h000A);
    check("st1_rdy", in_ready, 1);
    in_sel = 2'd1;
    tick();
    check("st2_rdy", in_ready, 0);
    check("st2_vld", out_valid, 1);
    check("st2_dat", out_data, 16'h000A);
    in_sel = 2'd3;
    tick();
    check("st3_hold", out_data, 16'h000A);
    check("st3_rdy", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("st4_first", out_data, 16'h000A);
    tick();
    check("st5_second", out_data, 16'h000B);
    check("st5_rdy", in_ready, 1);
    check("st5_vld", out_valid, 1);
    tick();
    check("st6_empty", out_valid, 0);

    // Flush while FULL with in_valid asserted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    check("fl_full", in_ready, 0);
    flush  = 1'b1;
    in_sel = 2'd2;
    tick();
    check("fl_vld", out_valid, 0);
    check("fl_rdy", in_ready, 1);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("fl_stay_empty", out_valid, 0);

    // Flush in ONE with simultaneous accept and drain: the new entry is dropped.
    in_valid = 1'b1;
    in_sel   = 2'd0;
    tick();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_sel    = 2'd3;
    tick();
    check("fl1_vld", out_valid, 0);
    flush  = 1'b0;
    in_sel = 2'd1;
    tick();
    check("fl1_next_dat", out_data, 16'h000B);
    check("fl1_next_vld", out_valid, 1);
    in_valid = 1'b0;
    tick();

    // Async reset while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    check("ar_full", in_ready, 0);
    in_valid = 1'b0;
    #3 arst_n = 1'b0;
    #1;
    check("ar_vld", out_valid, 0);
    check("ar_rdy", in_ready, 1);
    check("ar_dat", out_data, 0);
    #1 arst_n = 1'b1;
    tick();
    check("ar_after_vld", out_valid, 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    tick();
    check("ar_res1", out_data, 16'h000C);
    in_sel = 2'd3;
    tick();
    check("ar_res2", out_data, 16'h000D);
    in_valid = 1'b0;
    tick();
    check("ar_res_empty", out_valid, 0);

    // Random streaming against a queue model.
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 100 && cyc < 2000) begin
      check("rnd_vld", out_valid, (q.size() != 0));
      check("rnd_rdy", in_ready, (q.size() < 2));
      if (q.size() != 0) check("rnd_dat", out_data, q[0]);
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = {$urandom(), $urandom()};
      out_ready = 1'($urandom_range(0, 1));
      drn = (q.size() != 0) && out_ready;
      acc = in_valid && (q.size() < 2);
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(in_data[in_sel*16 +: 16]);
        acc_n++;
      end
      tick();
      cyc++;
    end
    check("rnd_done", acc_n, 100);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (q.size() != 0) begin
        check("rnd_tail_dat", out_data, q[0]);
        void'(q.pop_front());
      end
      tick();
    end
    check("rnd_final_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_skid.md
Name: mux_n_skid

Overview:
- Parametrised N-way data selector with a registered, elastic output stage.
- Picks one of N_IN packed inputs by a select index, then captures the result into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Used between pipeline stages where a forwarding or operand mux must be registered and must tolerate downstream stalls without combinational ready paths.

Parameters:
- DATA_W, 16, width of each data input and of the output.
- N_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_IN (elaboration error otherwise).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- arst_n  input  1  asynchronous active-low reset.
- in_data  input  N_IN*DATA_W  packed inputs; input k occupies bits [k*DATA_W +: DATA_W].
- in_sel  input  SEL_W  select index, sampled with in_data.
- in_valid  input  1  upstream offers in_data/in_sel this cycle.
- in_ready  output  1  block can accept this cycle; driven directly from state, no combinational path from out_ready.
- flush  input  1  synchronous discard of all buffered entries.
- out_data  output  DATA_W  selected data of the oldest buffered entry.
- out_sel_oor  output  1  oldest entry was captured with in_sel >= N_IN.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Selection rule:
  - in_sel < N_IN: input in_sel is selected.
  - in_sel >= N_IN: input N_IN-1 is selected and the entry's out_sel_oor bit is set.
  - out_sel_oor travels with its entry.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Drain occurs when out_valid && out_ready.
  - in_valid, in_data and in_sel are don't-care while in_ready=0.
- Storage is two entries: main (drives outputs) and skid. The state machine is:
  - EMPTY: main and skid invalid; out_valid=0, in_ready=1.
  - ONE: main valid; out_valid=1, in_ready=1.
  - FULL: main and skid valid; out_valid=1, in_ready=0.
- Transitions (flush=0):
  - EMPTY, accept -> ONE. The new entry is in main next cycle, so latency is 1 cycle.
  - ONE, accept and drain -> ONE; main is replaced by the new entry.
  - ONE, accept and no drain -> FULL; the new entry goes to skid.
  - ONE, drain and no accept -> EMPTY.
  - FULL, drain -> ONE; skid moves to main.
  - FULL, no drain -> FULL; all outputs held stable.
  - Any other combination -> no change.
- Ordering: strict FIFO order is always preserved; no entry is lost or duplicated.
- Stall stability: while out_valid=1 and out_ready=0, out_data and out_sel_oor must not change.
- flush:
  - Next state is EMPTY regardless of accept or drain in the same cycle.
  - An entry accepted in the flush cycle is discarded.
  - A drain in the flush cycle still counts as delivered downstream.
- Reset:
  - State EMPTY; out_valid=0, out_data=0, out_sel_oor=0, skid contents 0, in_ready=1.
  - Reset asserted mid-operation discards all entries immediately (asynchronous).
  - No accept occurs while arst_n=0.
- Invalid entries: data registers of invalid entries need not be cleared except at reset.
- Width rules:
  - No arithmetic; widths are exact.
  - SEL_W wider than needed is legal; the extra select bits only feed the out-of-range detection.

Test Plan:
- Reset with N_IN=4, DATA_W=16 -> out_valid=0, out_data=0, out_sel_oor=0, in_ready=1 both during reset and in the first cycle after release.
- Inputs {0x000A, 0x000B, 0x000C, 0x000D}, out_ready=1, in_sel=2 for one cycle -> next cycle out_data=0x000C, out_valid=1, out_sel_oor=0. With N_IN=3, SEL_W=2, in_sel=3 -> out_data=input 2, out_sel_oor=1.
- out_ready=0, push sel 0 then sel 1 -> FULL, in_ready=0, out_data=0x000A held stable. Raise out_ready -> 0x000A then 0x000B delivered on consecutive cycles, in_ready returns to 1 after the first drain.
- Streaming 100 random accepts with out_ready toggling randomly -> scoreboard matches order exactly, and in_ready=0 occurs only in FULL.
- FULL state plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed input never appears at the output.
- arst_n pulsed low mid-stream in FULL state -> out_valid drops within the same cycle without a clock edge, and later traffic resumes in order.
